clk_period_meter: RTL and testbench

- Measures a slow, divided clock or any slow square wave (`sig_in`) against the fast system clock `clk_in`.
- Reports, in `clk_in` cycles:
  - the period (rising edge to rising edge);
  - the high time (rising edge to falling edge).
- Flags a period outside an expected window, and detects loss of the signal.
- Sits on the consumer side of the team's clock dividers. Used for bring-up checks and to qualify display/keypad scan clocks.

---
 rtl/clk_period_meter.sv | 121 ++++++++++++
 tb/tb_clk_period_meter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow signal in clk_in cycles, flags
// out-of-window periods and declares signal loss after TIMEOUT idle cycles.
module clk_period_meter #(
  parameter int unsigned W        = 20,
  parameter int unsigned EXPECTED = 130002,
  parameter int unsigned TOL      = 16,
  parameter int unsigned TIMEOUT  = 200000
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         sig_in,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         period_valid,
  output logic         in_tol,
  output logic         locked,
  output logic         timeout
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [W-1:0] EXP_W   = W'(EXPECTED);
  localparam logic [W-1:0] TO_LAST = W'(TIMEOUT - 1);
  localparam logic [W:0]   TOL_W   = (W+1)'(TOL);

  logic         r_s1;
  logic         r_s2;
  logic         r_sp;
  logic [1:0]   r_settle;
  logic [1:0]   r_state;
  logic [W-1:0] r_cnt;

  logic         w_settled;
  logic         w_rise;
  logic         w_fall;
  logic         w_expire;
  logic [W-1:0] w_cnt_inc;
  logic [W:0]   w_diff;
  logic         w_in_tol;

  // Edges stay masked until sp has caught up with the first post-reset s2,
  // so a level already high at release never looks like a rising edge.
  assign w_settled = (r_settle == 2'd3);
  assign w_rise    = w_settled &  r_s2 & ~r_sp;
  assign w_fall    = w_settled & ~r_s2 &  r_sp;
  assign w_cnt_inc = r_cnt + W'(1);
  assign w_expire  = (r_state != ST_IDLE) && (r_cnt == TO_LAST) && !w_rise;

  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    w_diff = '0;
    if (w_cnt_inc >= EXP_W) w_diff = {1'b0, w_cnt_inc} - {1'b0, EXP_W};
    else                    w_diff = {1'b0, EXP_W} - {1'b0, w_cnt_inc};
  end

  assign w_in_tol = (w_diff <= TOL_W);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from before the clock edge.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_sp     <= 1'b0;
      r_settle <= 2'd0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_sp <= r_s2;
      if (!w_settled) r_settle <= r_settle + 2'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      in_tol       <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_rise) r_state <= ST_ARMED;
        end
        ST_ARMED, ST_LOCKED: begin
          if (w_rise) begin
            r_cnt        <= '0;
            period       <= w_cnt_inc;
            in_tol       <= w_in_tol;
            period_valid <= 1'b1;
            locked       <= 1'b1;
            r_state      <= ST_LOCKED;
          end else if (w_expire) begin
            r_cnt   <= '0;
            timeout <= 1'b1;
            locked  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
          if (w_fall) high_time <= w_cnt_inc;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter, scaled down (EXPECTED=1000, TIMEOUT=2000)
// so the whole scenario runs in a few tens of thousands of cycles.
module tb_clk_period_meter;

  localparam int unsigned W        = 12;
  localparam int unsigned EXPECTED = 1000;
  localparam int unsigned TOL      = 16;
  localparam int unsigned TIMEOUT  = 2000;
  localparam int          HIGH     = 500;

  logic         clk_in;
  logic         reset;
  logic         sig_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         period_valid;
  logic         in_tol;
  logic         locked;
  logic         timeout;

  int n_checks = 0;
  int n_errors = 0;

  int cyc         = 0;
  int pv_cnt      = 0;
  int to_cnt      = 0;
  int last_pv_cyc = 0;
  int last_to_cyc = 0;

  clk_period_meter #(
    .W(W), .EXPECTED(EXPECTED), .TOL(TOL), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .sig_in(sig_in),
    .period(period),
    .high_time(high_time),
    .period_valid(period_valid),
    .in_tol(in_tol),
    .locked(locked),
    .timeout(timeout)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Pulse monitor, sampling on the inactive edge.
  always @(negedge clk_in) begin
    cyc = cyc + 1;
    if (period_valid === 1'b1) begin
      pv_cnt      = pv_cnt + 1;
      last_pv_cyc = cyc;
    end
    if (timeout === 1'b1) begin
      to_cnt      = to_cnt + 1;
      last_to_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Low phase then a HIGH-cycle high phase; returns mid-high, well after the
  // rising edge has been reported, so consecutive calls give period == p.
  task automatic wave(input int p);
    sig_in = 1'b0;
    wait_cycles(p - HIGH);
    sig_in = 1'b1;
    wait_cycles(HIGH);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_period"},    32'(period),    0);
    check({pfx, "_high_time"}, 32'(high_time), 0);
    check({pfx, "_pv"},        32'(period_valid), 0);
    check({pfx, "_in_tol"},    32'(in_tol),    0);
    check({pfx, "_locked"},    32'(locked),    0);
    check({pfx, "_timeout"},   32'(timeout),   0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int pv0;
    int to0;
    int n;

    reset  = 1'b1;
    sig_in = 1'b0;
    wait_cycles(4);
    check_all_zero("reset");
    reset = 1'b0;
    wait_cycles(5);

    // First rise only arms
    pv0 = pv_cnt;
    wave(1000);
    check("arm_no_pv", 32'(pv_cnt - pv0), 0);
    check("arm_not_locked", 32'(locked), 0);

    // Nominal square wave
    pv0 = pv_cnt;
    repeat (3) wave(1000);
    check("nom_pv_count", 32'(pv_cnt - pv0), 3);
    check("nom_period",   32'(period),    1000);
    check("nom_high",     32'(high_time), 500);
    check("nom_in_tol",   32'(in_tol),    1);
    check("nom_locked",   32'(locked),    1);

    wave(1028);
    check("p1028_period", 32'(period), 1028);
    check("p1028_in_tol", 32'(in_tol), 0);
    check("p1028_locked", 32'(locked), 1);

    wave(984);
    check("p984_period", 32'(period), 984);
    check("p984_in_tol", 32'(in_tol), 1);

    wave(1016);
    check("p1016_in_tol", 32'(in_tol), 1);
    wave(1017);
    check("p1017_period", 32'(period), 1017);
    check("p1017_in_tol", 32'(in_tol), 0);

    wave(1000);
    check("back_period", 32'(period), 1000);
    check("back_in_tol", 32'(in_tol), 1);

    // Signal loss
    to0    = to_cnt;
    sig_in = 1'b0;
    n      = 0;
    while (to_cnt == to0 && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    check("timeout_seen", 32'(to_cnt - to0), 1);
    wait_cycles(500);
    check("timeout_once",   32'(to_cnt - to0), 1);
    check("timeout_delay",  32'(last_to_cyc - last_pv_cyc), TIMEOUT);
    check("timeout_locked", 32'(locked), 0);
    check("timeout_period", 32'(period), 1000);
    check("timeout_in_tol", 32'(in_tol), 1);

    // Recovery needs two rises
    pv0 = pv_cnt;
    wave(1000);
    check("rearm_no_pv",  32'(pv_cnt - pv0), 0);
    check("rearm_locked", 32'(locked), 0);
    wave(1000);
    check("relock_pv",     32'(pv_cnt - pv0), 1);
    check("relock_period", 32'(period), 1000);
    check("relock_locked", 32'(locked), 1);

    // One-cycle reset mid-period while locked
    sig_in = 1'b0;
    wait_cycles(200);
    pv0   = pv_cnt;
    to0   = to_cnt;
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    check_all_zero("midrst");
    wave(1000);
    check("midrst_no_pv",  32'(pv_cnt - pv0), 0);
    check("midrst_no_to",  32'(to_cnt - to0), 0);
    check("midrst_arm_lk", 32'(locked), 0);
    wave(1000);
    check("midrst_relock_pv",  32'(pv_cnt - pv0), 1);
    check("midrst_relock_per", 32'(period), 1000);
    check("midrst_relock_lk",  32'(locked), 1);

    // Level held high through reset must not arm
    sig_in = 1'b1;
    wait_cycles(20);
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    pv0 = pv_cnt;
    to0 = to_cnt;
    wait_cycles(TIMEOUT + 200);
    check("held_no_pv",   32'(pv_cnt - pv0), 0);
    check("held_no_to",   32'(to_cnt - to0), 0);
    check("held_locked",  32'(locked), 0);
    wave(1000);
    check("held_arm_no_pv", 32'(pv_cnt - pv0), 0);
    check("held_arm_lk",    32'(locked), 0);
    wave(1000);
    check("held_lock_pv",   32'(pv_cnt - pv0), 1);
    check("held_lock_per",  32'(period), 1000);
    check("held_lock_high", 32'(high_time), 500);
    check("held_lock_lk",   32'(locked), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
